// File: rtl/ota_cfg_spi_if.sv
// Pin bundle of the OTA configuration port: serial inputs, status outputs
// and the two analog trim control bytes.
interface ota_cfg_spi_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena, ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ena, ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/ota_cfg_spi.sv
// Mode-0 SPI slave holding three 8-bit configuration registers (OUT, OE,
// SCRATCH). 16-bit frames: R/W bit, 7-bit address, 8-bit data, MSB first.
// All serial pins are oversampled by clk through synchronizers.
module ota_cfg_spi #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic         clk,
   input logic         rst_n,
   ota_cfg_spi_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, csn_sync;
   logic                   sclk_prev_q;
   logic                   sclk_s, mosi_s, csn_s, sclk_rise, sclk_fall;

   logic [4:0] cnt_q, cnt_d;
   logic [7:0] cmd_q, cmd_d;
   logic [6:0] data_q, data_d;
   logic [7:0] tx_q, tx_d;
   logic       miso_q, miso_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [7:0] out_q, out_d;
   logic [7:0] oe_q, oe_d;
   logic [7:0] scratch_q, scratch_d;

   logic [7:0] cmd_shift;
   logic [7:0] data_shift;
   logic [7:0] rd_value;
   logic       addr_ok;
   logic       unused_inputs;

   assign unused_inputs = ^{bus.ena, bus.uio_in, bus.ui_in[7:3]};

   // Pin synchronizers plus one extra SCLK stage for edge detection.
   // CS_N resets to the deselected level so reset never looks like a frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync   <= '0;
         mosi_sync   <= '0;
         csn_sync    <= '1;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync[0] <= bus.ui_in[0];
         mosi_sync[0] <= bus.ui_in[1];
         csn_sync[0]  <= bus.ui_in[2];
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sclk_sync[i] <= sclk_sync[i-1];
            mosi_sync[i] <= mosi_sync[i-1];
            csn_sync[i]  <= csn_sync[i-1];
         end
         sclk_prev_q <= sclk_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign csn_s     = csn_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;

   assign cmd_shift  = {cmd_q[6:0], mosi_s};
   assign data_shift = {data_q, mosi_s};
   assign addr_ok    = (cmd_q[6:0] < 7'd3);

   // Read-back value for the command byte completing on this rise.
   always_comb begin
      rd_value = 8'h00;
      unique case (cmd_shift[6:0])
         7'd0:    rd_value = out_q;
         7'd1:    rd_value = oe_q;
         7'd2:    rd_value = scratch_q;
         default: rd_value = 8'h00;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         cmd_q     <= '0;
         data_q    <= '0;
         tx_q      <= '0;
         miso_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         out_q     <= '0;
         oe_q      <= '0;
         scratch_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_d;
         data_q    <= data_d;
         tx_q      <= tx_d;
         miso_q    <= miso_d;
         done_q    <= done_d;
         err_q     <= err_d;
         out_q     <= out_d;
         oe_q      <= oe_d;
         scratch_q <= scratch_d;
      end
   end

   // Frame sequencing: command byte, data byte, then ignore SCLK until deselect.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      data_d    = data_q;
      tx_d      = tx_q;
      miso_d    = miso_q;
      done_d    = 1'b0;
      err_d     = err_q;
      out_d     = out_q;
      oe_d      = oe_q;
      scratch_d = scratch_q;

      if (csn_s) begin
         // Deselect aborts any partial frame without side effects.
         state_d = StIdle;
         cnt_d   = '0;
         miso_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               cnt_d   = '0;
               miso_d  = 1'b0;
               state_d = StCmd;
            end
            StCmd: begin
               if (sclk_rise) begin
                  cmd_d = cmd_shift;
                  cnt_d = cnt_q + 5'd1;
                  if (cnt_q == 5'd7) begin
                     state_d = StData;
                     tx_d    = cmd_shift[7] ? rd_value : 8'h00;
                  end
               end
            end
            StData: begin
               // Counter parks at 16 so trailing rises are ignored.
               if (sclk_rise && cnt_q != 5'd16) begin
                  data_d = data_shift[6:0];
                  cnt_d  = cnt_q + 5'd1;
                  if (cnt_q == 5'd15) begin
                     done_d = 1'b1;
                     err_d  = ~addr_ok;
                     if (!cmd_q[7]) begin
                        unique case (cmd_q[6:0])
                           7'd0:    out_d     = data_shift;
                           7'd1:    oe_d      = data_shift;
                           7'd2:    scratch_d = data_shift;
                           default: ;
                        endcase
                     end
                  end
               end
               if (sclk_fall && cmd_q[7]) begin
                  miso_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign bus.uo_out  = {5'b00000, err_q, done_q, miso_q};
   assign bus.uio_out = out_q;
   assign bus.uio_oe  = oe_q;

endmodule

// File: tb/tb_ota_cfg_spi.sv
// Self-checking bench for ota_cfg_spi: directed frames with literal
// expectations, then random frames checked every cycle against a
// frame-level reference model.
module tb_ota_cfg_spi;

   logic clk = 1'b0;
   logic rst_n;

   ota_cfg_spi_if bus ();

   ota_cfg_spi #(.SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Pin drivers; unused pins carry noise to show they are ignored.
   logic       sclk_pin, mosi_pin, csn_pin;
   logic [7:0] junk;
   assign bus.ui_in  = {junk[4:0], csn_pin, mosi_pin, sclk_pin};
   assign bus.uio_in = junk;
   assign bus.ena    = junk[7];

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a pin change takes effect two clk edges after it is
   // sampled; beyond that the model works on whole frames.
   logic [7:0]  m_regs [3];
   logic        m_err, m_done, m_miso, m_rd;
   logic [3:0]  h_sclk, h_mosi, h_csn;
   logic [15:0] m_sh;
   logic [7:0]  m_tx;
   int          m_cnt, m_nf;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_regs[i] = 8'h00;
      m_err = 0; m_done = 0; m_miso = 0; m_rd = 0;
      h_sclk = 4'h0; h_mosi = 4'h0; h_csn = 4'hF;
      m_sh = 16'h0; m_tx = 8'h0; m_cnt = 0; m_nf = 0;
   endtask

   task automatic model_step();
      int a;
      h_sclk = {h_sclk[2:0], bus.ui_in[0]};
      h_mosi = {h_mosi[2:0], bus.ui_in[1]};
      h_csn  = {h_csn[2:0], bus.ui_in[2]};
      m_done = 0;
      if (h_csn[2]) begin
         m_cnt = 0; m_nf = 0; m_miso = 0; m_rd = 0;
      end else if (h_sclk[2] && !h_sclk[3]) begin
         if (m_cnt < 16) begin
            m_sh = {m_sh[14:0], h_mosi[2]};
            m_cnt++;
            if (m_cnt == 8) begin
               a    = int'(m_sh[6:0]);
               m_rd = m_sh[7];
               m_nf = 0;
               m_tx = (a < 3) ? m_regs[a] : 8'h00;
            end
            if (m_cnt == 16) begin
               a      = int'(m_sh[14:8]);
               m_done = 1;
               if (a < 3) begin
                  m_err = 0;
                  if (!m_sh[15]) m_regs[a] = m_sh[7:0];
               end else begin
                  m_err = 1;
               end
            end
         end
      end else if (!h_sclk[2] && h_sclk[3] && m_cnt >= 8 && m_rd) begin
         m_nf++;
         m_miso = (m_nf <= 8) ? m_tx[8-m_nf] : 1'b0;
      end
   endtask

   // Model advances on the same edges as the design.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (check_en) begin
         chk("uio_out", bus.uio_out, m_regs[0]);
         chk("uio_oe", bus.uio_oe, m_regs[1]);
         chk("miso", 8'(bus.uo_out[0]), 8'(m_miso));
         chk("done", 8'(bus.uo_out[1]), 8'(m_done));
         chk("err", 8'(bus.uo_out[2]), 8'(m_err));
         chk("uo_hi", 8'(bus.uo_out[7:3]), 8'h00);
         if (bus.uo_out[1]) n_done++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One CS_N-framed transfer of nbits SCLK periods (12 clk each).
   // Captures the read byte from MISO just before rises 9..16.
   task automatic frame(input logic [15:0] word, input int nbits, input bit rst_mid,
                        output logic [7:0] rd);
      rd = 8'h00;
      csn_pin = 1'b0;
      tick(4);
      for (int i = 0; i < nbits; i++) begin
         mosi_pin = (i < 16) ? word[15-i] : 1'($urandom);
         junk     = 8'($urandom);
         tick(6);
         if (i >= 8 && i < 16) rd[15-i] = bus.uo_out[0];
         sclk_pin = 1'b1;
         if (i == 15) begin
            tick(2);
            chk("done_lat2", 8'(bus.uo_out[1]), 8'h00);
            tick(1);
            chk("done_lat3", 8'(bus.uo_out[1]), 8'h01);
            tick(1);
            chk("done_width", 8'(bus.uo_out[1]), 8'h00);
            tick(2);
         end else begin
            tick(6);
         end
         sclk_pin = 1'b0;
      end
      tick(6);
      if (rst_mid) begin
         rst_n = 1'b0;
         tick(2);
         rst_n = 1'b1;
         tick(2);
      end
      csn_pin = 1'b1;
      tick(8);
   endtask

   logic [7:0] rd;
   int         d0, r, nb;
   logic [15:0] w;

   initial begin
      sclk_pin = 1'b0; mosi_pin = 1'b0; csn_pin = 1'b1; junk = 8'h00;
      rst_n = 1'b0;
      tick(3);
      check_en = 1'b1;
      chk("rst_uio_out", bus.uio_out, 8'h00);
      chk("rst_uio_oe", bus.uio_oe, 8'h00);
      chk("rst_uo_out", bus.uo_out, 8'h00);
      rst_n = 1'b1;
      tick(3);

      frame(16'h003C, 16, 1'b0, rd);
      chk("wr_out", bus.uio_out, 8'h3C);
      chk("wr_out_err", 8'(bus.uo_out[2]), 8'h00);

      frame(16'h01FF, 16, 1'b0, rd);
      frame(16'h8100, 16, 1'b0, rd);
      chk("rd_oe", rd, 8'hFF);
      chk("oe_val", bus.uio_oe, 8'hFF);

      frame(16'h0512, 16, 1'b0, rd);
      chk("bad_addr_err", 8'(bus.uo_out[2]), 8'h01);
      chk("bad_addr_out", bus.uio_out, 8'h3C);
      frame(16'h8700, 16, 1'b0, rd);
      chk("bad_addr_rd", rd, 8'h00);
      frame(16'h0277, 16, 1'b0, rd);
      chk("err_clear", 8'(bus.uo_out[2]), 8'h00);
      frame(16'h8200, 16, 1'b0, rd);
      chk("rd_scratch", rd, 8'h77);

      d0 = n_done;
      frame(16'h0055, 10, 1'b0, rd);
      chk("partial_out", bus.uio_out, 8'h3C);
      chk("partial_done", 8'(n_done - d0), 8'h00);
      frame(16'h0011, 16, 1'b0, rd);
      chk("after_partial", bus.uio_out, 8'h11);

      d0 = n_done;
      frame(16'h00A5, 20, 1'b0, rd);
      chk("long_out", bus.uio_out, 8'hA5);
      chk("long_done", 8'(n_done - d0), 8'h01);

      frame(16'h005A, 12, 1'b1, rd);
      chk("midrst_out", bus.uio_out, 8'h00);
      chk("midrst_oe", bus.uio_oe, 8'h00);
      frame(16'h0042, 16, 1'b0, rd);
      chk("post_rst", bus.uio_out, 8'h42);

      // Random frames; correctness comes from the per-cycle model compare.
      for (int k = 0; k < 60; k++) begin
         w = {1'($urandom), 7'($urandom_range(0, 4)), 8'($urandom)};
         r = $urandom_range(0, 9);
         if (r <= 5)      frame(w, 16, 1'b0, rd);
         else if (r == 6) frame(w, $urandom_range(1, 15), 1'b0, rd);
         else if (r <= 8) frame(w, $urandom_range(17, 20), 1'b0, rd);
         else begin
            nb = $urandom_range(3, 14);
            frame(w, nb, 1'b1, rd);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
